// File: rtl/recovered_clock_generator.sv
// rtl/recovered_clock_generator.sv - phase-aligned bit clock regenerated from recovered I/O edges
//
// Packages:
//   common_p     - clk_dom_s: clock plus synchronous active-low reset bundle.
//   clks_alot_p  - RATE_COUNTER_WIDTH and recovered_events_s (edge flags from rate recovery).
//
// recovered_clock_generator ports:
//   sys_dom_i          clock domain (clk, rst_n; reset synchronous, active-low)
//   generator_en_i     enable; low forces IDLE
//   clear_state_i      synchronous clear to IDLE with reset values
//   locked_in_i        upstream rate lock
//   speed_change_i     single-cycle speed-change pulse, forces realignment
//   rate_i             period minus one, in clk cycles
//   sample_offset_i    sample phase; 0 or beyond rate_i selects rate_i>>1
//   io_events_i        recovered edge flags; only any_valid_edge is consumed
//   recovered_clk_o    regenerated clock level (high for phase <= rate_i>>1)
//   edge_strobe_o      one-cycle pulse at phase 0
//   sample_strobe_o    one-cycle pulse at the sample phase
//   aligned_o          high in TRACK or HOLDOVER
//   holdover_o         high while at least one period has been missed
//   lost_alignment_o   one-cycle pulse when holdover gives up and realigns
//   phase_o            current phase counter
//   phase_error_o      cycles early of the last tracked event, held between events

package common_p;
  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;
endpackage

package clks_alot_p;
  localparam int RATE_COUNTER_WIDTH = 8;

  typedef struct packed {
    logic rising_edge;
    logic falling_edge;
    logic any_valid_edge;
  } recovered_events_s;
endpackage

module recovered_clock_generator #(
  parameter int RATE_WIDTH         = clks_alot_p::RATE_COUNTER_WIDTH,
  parameter int MAX_MISSED_PERIODS = 8,
  parameter int MISS_WIDTH         = $clog2(MAX_MISSED_PERIODS + 1)
) (
  input  common_p::clk_dom_s             sys_dom_i,
  input  logic                           generator_en_i,
  input  logic                           clear_state_i,
  input  logic                           locked_in_i,
  input  logic                           speed_change_i,
  input  logic [RATE_WIDTH-1:0]          rate_i,
  input  logic [RATE_WIDTH-1:0]          sample_offset_i,
  input  clks_alot_p::recovered_events_s io_events_i,
  output logic                           recovered_clk_o,
  output logic                           edge_strobe_o,
  output logic                           sample_strobe_o,
  output logic                           aligned_o,
  output logic                           holdover_o,
  output logic                           lost_alignment_o,
  output logic [RATE_WIDTH-1:0]          phase_o,
  output logic [RATE_WIDTH-1:0]          phase_error_o
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ALIGN    = 2'd1;
  localparam logic [1:0] ST_TRACK    = 2'd2;
  localparam logic [1:0] ST_HOLDOVER = 2'd3;

  localparam logic [MISS_WIDTH-1:0] MISS_LIMIT = MISS_WIDTH'(MAX_MISSED_PERIODS);
  localparam logic [MISS_WIDTH-1:0] MISS_ONE   = MISS_WIDTH'(1);
  localparam logic [RATE_WIDTH-1:0] PHASE_ONE  = RATE_WIDTH'(1);

  logic                  clk;
  logic                  rst_n;
  logic                  event_valid;
  wire                   unused_events = io_events_i.rising_edge ^ io_events_i.falling_edge;

  assign clk         = sys_dom_i.clk;
  assign rst_n       = sys_dom_i.rst_n;
  assign event_valid = io_events_i.any_valid_edge;

  // Registered state
  logic [1:0]            state;
  logic [RATE_WIDTH-1:0] phase;
  logic [MISS_WIDTH-1:0] missed;
  logic [RATE_WIDTH-1:0] phase_err;

  // Next-state values
  logic [1:0]            state_n;
  logic [RATE_WIDTH-1:0] phase_n;
  logic [MISS_WIDTH-1:0] missed_n;
  logic [RATE_WIDTH-1:0] phase_err_n;
  logic                  lost_n;

  // Registered outputs
  logic                  clk_q;
  logic                  edge_q;
  logic                  sample_q;
  logic                  aligned_q;
  logic                  holdover_q;
  logic                  lost_q;

  logic                  idle_cond;
  logic                  wrap;
  logic [RATE_WIDTH-1:0] half_rate;
  logic [RATE_WIDTH-1:0] sample_point;
  logic                  aligned_n;

  assign idle_cond = !generator_en_i || !locked_in_i || (rate_i == '0);
  // >= rather than == so a rate decrease mid-period wraps at once
  assign wrap      = (phase >= rate_i);
  assign half_rate = rate_i >> 1;

  always_comb begin
    sample_point = sample_offset_i;
    if ((sample_offset_i == '0) || (sample_offset_i > rate_i)) begin
      sample_point = half_rate;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    missed_n    = missed;
    phase_err_n = phase_err;
    lost_n      = 1'b0;

    if (clear_state_i || idle_cond) begin
      state_n     = ST_IDLE;
      phase_n     = '0;
      missed_n    = '0;
      phase_err_n = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n     = ST_ALIGN;
          phase_n     = '0;
          missed_n    = '0;
          phase_err_n = '0;
        end

        ST_ALIGN: begin
          if (event_valid) begin
            state_n     = ST_TRACK;
            phase_n     = '0;
            missed_n    = '0;
            phase_err_n = '0;
          end
        end

        ST_TRACK, ST_HOLDOVER: begin
          if (speed_change_i) begin
            state_n     = ST_ALIGN;
            phase_n     = '0;
            missed_n    = '0;
            phase_err_n = '0;
          end else if (event_valid) begin
            state_n     = ST_TRACK;
            phase_n     = '0;
            missed_n    = '0;
            // An event landing on the wrap is exactly on time
            phase_err_n = wrap ? '0 : (rate_i - phase);
          end else if (wrap) begin
            phase_n = '0;
            if ((missed + MISS_ONE) >= MISS_LIMIT) begin
              state_n     = ST_ALIGN;
              missed_n    = '0;
              phase_err_n = '0;
              lost_n      = 1'b1;
            end else begin
              state_n  = ST_HOLDOVER;
              missed_n = missed + MISS_ONE;
            end
          end else begin
            phase_n = phase + PHASE_ONE;
          end
        end

        default: begin
          state_n     = ST_IDLE;
          phase_n     = '0;
          missed_n    = '0;
          phase_err_n = '0;
        end
      endcase
    end
  end

  assign aligned_n = (state_n == ST_TRACK) || (state_n == ST_HOLDOVER);

  // Outputs are decoded from next-state values and registered so that they
  // line up with the phase register and carry no path from the inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      phase      <= '0;
      missed     <= '0;
      phase_err  <= '0;
      clk_q      <= 1'b0;
      edge_q     <= 1'b0;
      sample_q   <= 1'b0;
      aligned_q  <= 1'b0;
      holdover_q <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      missed     <= missed_n;
      phase_err  <= phase_err_n;
      clk_q      <= aligned_n && (phase_n <= half_rate);
      edge_q     <= aligned_n && (phase_n == '0);
      sample_q   <= aligned_n && (phase_n == sample_point);
      aligned_q  <= aligned_n;
      holdover_q <= aligned_n && (missed_n != '0);
      lost_q     <= lost_n;
    end
  end

  assign recovered_clk_o  = clk_q;
  assign edge_strobe_o    = edge_q;
  assign sample_strobe_o  = sample_q;
  assign aligned_o        = aligned_q;
  assign holdover_o       = holdover_q;
  assign lost_alignment_o = lost_q;
  assign phase_o          = phase;
  assign phase_error_o    = phase_err;

endmodule

// File: tb/tb_recovered_clock_generator.sv
// tb/tb_recovered_clock_generator.sv - directed self-checking bench for recovered_clock_generator

module tb_recovered_clock_generator;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clear;
  logic       locked;
  logic       speed;
  logic [7:0] rate;
  logic [7:0] offset;
  logic       ev;

  common_p::clk_dom_s             sys_dom;
  clks_alot_p::recovered_events_s io_ev;

  logic       rclk;
  logic       edge_s;
  logic       samp_s;
  logic       aligned;
  logic       holdover;
  logic       lost;
  logic [7:0] phase;
  logic [7:0] perr;

  int tests;
  int fails;

  assign sys_dom = '{clk: clk, rst_n: rst_n};
  assign io_ev   = '{rising_edge: 1'b0, falling_edge: 1'b0, any_valid_edge: ev};

  recovered_clock_generator #(
    .MAX_MISSED_PERIODS(3)
  ) dut (
    .sys_dom_i        (sys_dom),
    .generator_en_i   (en),
    .clear_state_i    (clear),
    .locked_in_i      (locked),
    .speed_change_i   (speed),
    .rate_i           (rate),
    .sample_offset_i  (offset),
    .io_events_i      (io_ev),
    .recovered_clk_o  (rclk),
    .edge_strobe_o    (edge_s),
    .sample_strobe_o  (samp_s),
    .aligned_o        (aligned),
    .holdover_o       (holdover),
    .lost_alignment_o (lost),
    .phase_o          (phase),
    .phase_error_o    (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_event();
    ev = 1'b1;
    tick();
    ev = 1'b0;
  endtask

  int hi;
  int samp_at;
  int extra_edges;
  int first_hold;
  int lost_at;
  int lost_cnt;
  int al_sum;

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    clear  = 1'b0;
    locked = 1'b0;
    speed  = 1'b0;
    rate   = 8'd0;
    offset = 8'd0;
    ev     = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_clk", rclk, 0);
    check("rst_edge", edge_s, 0);
    check("rst_aligned", aligned, 0);
    check("rst_phase", phase, 0);
    check("rst_perr", perr, 0);

    // Rate 9, periodic events every 10 cycles
    rst_n  = 1'b1;
    en     = 1'b1;
    locked = 1'b1;
    rate   = 8'd9;
    tick();
    check("align_not_aligned", aligned, 0);
    pulse_event();
    check("first_edge", edge_s, 1);
    check("first_aligned", aligned, 1);
    check("first_phase", phase, 0);
    hi = rclk;
    samp_at = -1;
    extra_edges = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      hi += int'(rclk);
      if (samp_s) samp_at = i;
      if (edge_s) extra_edges++;
    end
    check("r9_clk_high_cycles", hi, 5);
    check("r9_sample_delay", samp_at, 4);
    check("r9_no_extra_edges", extra_edges, 0);
    check("r9_phase_end", phase, 9);
    pulse_event();
    check("r9_on_time_edge", edge_s, 1);
    check("r9_on_time_perr", perr, 0);
    check("r9_no_holdover", holdover, 0);

    // One event two cycles early
    for (int i = 0; i < 7; i++) tick();
    pulse_event();
    check("early_perr", perr, 2);
    check("early_phase", phase, 0);
    check("early_edge", edge_s, 1);
    samp_at = -1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (samp_s) samp_at = i;
    end
    check("early_sample_reanchor", samp_at, 4);
    check("early_perr_held", perr, 2);

    // Events stop: holdover then loss after three missed wraps
    first_hold = -1;
    lost_at = -1;
    lost_cnt = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (holdover && first_hold < 0) first_hold = i;
      if (lost) begin
        lost_cnt++;
        lost_at = i;
      end
      if (i == 1) check("hold_free_edge", edge_s, 1);
      if (i == 20) check("hold_aligned_before_loss", aligned, 1);
    end
    check("hold_first_tick", first_hold, 1);
    check("lost_tick", lost_at, 21);
    check("lost_count", lost_cnt, 1);
    check("lost_aligned_low", aligned, 0);
    check("lost_holdover_low", holdover, 0);
    pulse_event();
    check("relock_aligned", aligned, 1);
    check("relock_edge", edge_s, 1);

    // Rate 7 with explicit sample offset 2, then out-of-range 12
    rate   = 8'd7;
    offset = 8'd2;
    pulse_event();
    hi = rclk;
    samp_at = -1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      hi += int'(rclk);
      if (samp_s) samp_at = int'(phase);
    end
    check("r7_clk_high_cycles", hi, 4);
    check("r7_sample_off2", samp_at, 2);
    offset = 8'd12;
    pulse_event();
    check("r7_wrap_event_perr", perr, 0);
    samp_at = -1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (samp_s) samp_at = int'(phase);
    end
    check("r7_sample_midpoint", samp_at, 3);

    // Speed change mid-track
    pulse_event();
    for (int i = 0; i < 3; i++) tick();
    speed = 1'b1;
    tick();
    speed = 1'b0;
    check("spd_aligned", aligned, 0);
    check("spd_clk", rclk, 0);
    check("spd_phase", phase, 0);
    lost_cnt = int'(lost);
    al_sum = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      lost_cnt += int'(lost);
      al_sum += int'(aligned);
    end
    check("spd_no_lost", lost_cnt, 0);
    check("spd_waits_align", al_sum, 0);
    pulse_event();
    check("spd_realign", aligned, 1);

    // Lock drop clears phase error and outputs
    for (int i = 0; i < 3; i++) tick();
    pulse_event();
    check("r7_early_perr", perr, 4);
    tick();
    tick();
    locked = 1'b0;
    tick();
    check("unlock_aligned", aligned, 0);
    check("unlock_clk", rclk, 0);
    check("unlock_perr", perr, 0);
    locked = 1'b1;
    tick();
    pulse_event();
    for (int i = 0; i < 3; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_aligned", aligned, 0);
    check("clear_phase", phase, 0);
    check("clear_edge", edge_s, 0);
    tick();
    pulse_event();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_aligned", aligned, 0);
    check("midrst_clk", rclk, 0);
    check("midrst_phase", phase, 0);

    // Rate 0 holds IDLE even with lock and events
    rate = 8'd0;
    tick();
    pulse_event();
    check("rate0_aligned", aligned, 0);
    check("rate0_edge", edge_s, 0);
    al_sum = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      al_sum += int'(aligned);
    end
    check("rate0_stays_idle", al_sum, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
